// File: rtl/alu_cmd_seq_if.sv
// ============================================================================
// Module   : alu_cmd_seq_if
// Brief    : Command, ALU-drive and result bundle for alu_cmd_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_cmd_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ctrl;
    logic [7:0] in_a;
    logic [7:0] in_b;

    logic [7:0] ALU_src1;
    logic [7:0] ALU_src2;
    logic       Ainvert;
    logic       Binvert;
    logic [1:0] op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_overflow;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_overflow;
    logic       out_err;

    // Sequencer side.
    modport slave (
        input  in_valid, in_ctrl, in_a, in_b,
        output in_ready,
        output ALU_src1, ALU_src2, Ainvert, Binvert, op,
        input  alu_result, alu_zero, alu_overflow,
        output out_valid, out_result, out_zero, out_overflow, out_err,
        input  out_ready
    );

    // Environment side: command source, ALU and result sink.
    modport master (
        output in_valid, in_ctrl, in_a, in_b,
        input  in_ready,
        input  ALU_src1, ALU_src2, Ainvert, Binvert, op,
        output alu_result, alu_zero, alu_overflow,
        input  out_valid, out_result, out_zero, out_overflow, out_err,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_seq.sv
// ============================================================================
// Module   : alu_cmd_seq
// Brief    : IDLE/EXEC/DONE command sequencer feeding an 8-bit ripple ALU.
//            Optional saturating overflow counter: ALU_CMD_SEQ_OVF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_seq (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_seq_if.slave      bus
`ifdef ALU_CMD_SEQ_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state_q,   w_state_d;
    logic [7:0] r_src1_q,    w_src1_d;
    logic [7:0] r_src2_q,    w_src2_d;
    logic       r_ainv_q,    w_ainv_d;
    logic       r_binv_q,    w_binv_d;
    logic [1:0] r_op_q,      w_op_d;
    logic       r_arith_q,   w_arith_d;
    logic       r_err_q,     w_err_d;
    logic [7:0] r_res_q,     w_res_d;
    logic       r_zero_q,    w_zero_d;
    logic       r_ovf_q,     w_ovf_d;
    logic       r_oerr_q,    w_oerr_d;

    logic       w_dec_ainv;
    logic       w_dec_binv;
    logic [1:0] w_dec_op;
    logic       w_dec_arith;
    logic       w_dec_err;

    // Control-code decode; illegal codes fall back to AND drive with err set.
    always_comb begin
        w_dec_ainv  = 1'b0;
        w_dec_binv  = 1'b0;
        w_dec_op    = 2'b00;
        w_dec_arith = 1'b0;
        w_dec_err   = 1'b0;
        case (bus.in_ctrl)
            4'b0000: ;
            4'b0001: w_dec_op = 2'b01;
            4'b0010: begin
                w_dec_op    = 2'b10;
                w_dec_arith = 1'b1;
            end
            4'b0110: begin
                w_dec_binv  = 1'b1;
                w_dec_op    = 2'b10;
                w_dec_arith = 1'b1;
            end
            4'b0111: begin
                w_dec_binv = 1'b1;
                w_dec_op   = 2'b11;
            end
            4'b1100: begin
                w_dec_ainv = 1'b1;
                w_dec_binv = 1'b1;
            end
            default: w_dec_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_src1_d  = r_src1_q;
        w_src2_d  = r_src2_q;
        w_ainv_d  = r_ainv_q;
        w_binv_d  = r_binv_q;
        w_op_d    = r_op_q;
        w_arith_d = r_arith_q;
        w_err_d   = r_err_q;
        w_res_d   = r_res_q;
        w_zero_d  = r_zero_q;
        w_ovf_d   = r_ovf_q;
        w_oerr_d  = r_oerr_q;
        case (r_state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_src1_d  = bus.in_a;
                    w_src2_d  = bus.in_b;
                    w_ainv_d  = w_dec_ainv;
                    w_binv_d  = w_dec_binv;
                    w_op_d    = w_dec_op;
                    w_arith_d = w_dec_arith;
                    w_err_d   = w_dec_err;
                    w_state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // The ALU only produces meaningful overflow for ADD/SUB.
                if (r_err_q) begin
                    w_res_d  = 8'h00;
                    w_zero_d = 1'b0;
                    w_ovf_d  = 1'b0;
                end else begin
                    w_res_d  = bus.alu_result;
                    w_zero_d = bus.alu_zero;
                    w_ovf_d  = bus.alu_overflow & r_arith_q;
                end
                w_oerr_d  = r_err_q;
                w_state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_src1_q  <= 8'h00;
            r_src2_q  <= 8'h00;
            r_ainv_q  <= 1'b0;
            r_binv_q  <= 1'b0;
            r_op_q    <= 2'b00;
            r_arith_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_res_q   <= 8'h00;
            r_zero_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_oerr_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_src1_q  <= w_src1_d;
            r_src2_q  <= w_src2_d;
            r_ainv_q  <= w_ainv_d;
            r_binv_q  <= w_binv_d;
            r_op_q    <= w_op_d;
            r_arith_q <= w_arith_d;
            r_err_q   <= w_err_d;
            r_res_q   <= w_res_d;
            r_zero_q  <= w_zero_d;
            r_ovf_q   <= w_ovf_d;
            r_oerr_q  <= w_oerr_d;
        end
    end

`ifdef ALU_CMD_SEQ_OVF_CNT_EN
    logic [7:0] r_ovf_cnt_q, w_ovf_cnt_d;

    // Saturating count of genuine arithmetic overflows seen at capture.
    always_comb begin
        w_ovf_cnt_d = r_ovf_cnt_q;
        if ((r_state_q == S_EXEC) && !r_err_q && r_arith_q && bus.alu_overflow
            && (r_ovf_cnt_q != 8'hFF)) begin
            w_ovf_cnt_d = r_ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt_q <= 8'h00;
        end else begin
            r_ovf_cnt_q <= w_ovf_cnt_d;
        end
    end

    assign ovf_count = r_ovf_cnt_q;
`endif

    assign bus.in_ready     = (r_state_q == S_IDLE);
    assign bus.out_valid    = (r_state_q == S_DONE);
    assign bus.ALU_src1     = r_src1_q;
    assign bus.ALU_src2     = r_src2_q;
    assign bus.Ainvert      = r_ainv_q;
    assign bus.Binvert      = r_binv_q;
    assign bus.op           = r_op_q;
    assign bus.out_result   = r_res_q;
    assign bus.out_zero     = r_zero_q;
    assign bus.out_overflow = r_ovf_q;
    assign bus.out_err      = r_oerr_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
// ============================================================================
// Module   : tb_alu_cmd_seq
// Brief    : Randomized self-checking bench for alu_cmd_seq with an ALU stub.
//            Exercises ovf_count when ALU_CMD_SEQ_OVF_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_seq;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   m_cnt;

    alu_cmd_seq_if bus ();

`ifdef ALU_CMD_SEQ_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    alu_cmd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ALU_CMD_SEQ_OVF_CNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ripple ALU: invert, add with carry-in = Binvert, select by op.
    logic [7:0] s_a1;
    logic [7:0] s_b1;
    logic [8:0] s_sum;
    logic       s_ovf;
    always_comb begin
        s_a1  = bus.Ainvert ? ~bus.ALU_src1 : bus.ALU_src1;
        s_b1  = bus.Binvert ? ~bus.ALU_src2 : bus.ALU_src2;
        s_sum = {1'b0, s_a1} + {1'b0, s_b1} + {8'd0, bus.Binvert};
        s_ovf = (s_a1[7] == s_b1[7]) && (s_sum[7] != s_a1[7]);
        case (bus.op)
            2'b00:   bus.alu_result = s_a1 & s_b1;
            2'b01:   bus.alu_result = s_a1 | s_b1;
            2'b10:   bus.alu_result = s_sum[7:0];
            default: bus.alu_result = {7'd0, s_sum[7] ^ s_ovf};
        endcase
        bus.alu_zero     = (bus.alu_result == 8'h00);
        bus.alu_overflow = s_ovf;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: operation semantics straight from the command table.
    task automatic ref_cmd(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] r, output logic z, output logic o,
                           output logic e, output logic [3:0] dec);
        int sa;
        int sb;
        int s;
        sa = $signed(a);
        sb = $signed(b);
        o  = 1'b0;
        e  = 1'b0;
        r  = 8'h00;
        case (c)
            4'b0000: begin r = a & b;  dec = 4'b0000; end
            4'b0001: begin r = a | b;  dec = 4'b0001; end
            4'b0010: begin
                s = sa + sb; r = 8'(s); o = (s > 127) || (s < -128); dec = 4'b0010;
            end
            4'b0110: begin
                s = sa - sb; r = 8'(s); o = (s > 127) || (s < -128); dec = 4'b0110;
            end
            4'b0111: begin r = (sa < sb) ? 8'h01 : 8'h00; dec = 4'b0111; end
            4'b1100: begin r = ~(a | b); dec = 4'b1100; end
            default: begin e = 1'b1; dec = 4'b0000; end
        endcase
        z = !e && (r == 8'h00);
    endtask

    task automatic chk_cnt(input string tag);
`ifdef ALU_CMD_SEQ_OVF_CNT_EN
        chk(tag, 32'(ovf_count), 32'(m_cnt));
`endif
    endtask

    task automatic run_cmd(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                           input int stall);
        logic [7:0] r;
        logic       z;
        logic       o;
        logic       e;
        logic [3:0] dec;
        ref_cmd(c, a, b, r, z, o, e, dec);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ctrl  = c;
        bus.in_a     = a;
        bus.in_b     = b;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_ctrl  = 4'($urandom);
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
        chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
        chk("exec_out_valid", 32'(bus.out_valid), 32'd0);
        chk("alu_src1", 32'(bus.ALU_src1), 32'(a));
        chk("alu_src2", 32'(bus.ALU_src2), 32'(b));
        chk("alu_decode", 32'({bus.Ainvert, bus.Binvert, bus.op}), 32'(dec));
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        if (!e && o && m_cnt < 255) m_cnt++;
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("out_result", 32'(bus.out_result), 32'(r));
        chk("out_zero", 32'(bus.out_zero), 32'(z));
        chk("out_overflow", 32'(bus.out_overflow), 32'(o));
        chk("out_err", 32'(bus.out_err), 32'(e));
        chk_cnt("ovf_count");
        // Offer a competing command throughout DONE; it must be ignored.
        bus.in_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_result", 32'({bus.out_result, bus.out_zero, bus.out_overflow, bus.out_err}),
                32'({r, z, o, e}));
            chk("hold_src1", 32'(bus.ALU_src1), 32'(a));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ret_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ret_in_ready", 32'(bus.in_ready), 32'd1);
        chk("ret_no_accept", 32'(bus.ALU_src1), 32'(a));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_drive"}, 32'({bus.ALU_src1, bus.ALU_src2, bus.Ainvert, bus.Binvert, bus.op}),
            32'd0);
        chk({tag, "_outs"}, 32'({bus.out_result, bus.out_zero, bus.out_overflow, bus.out_err}),
            32'd0);
        chk_cnt({tag, "_ovf_count"});
    endtask

    // Reset while a command is in EXEC (phase 1) or DONE (phase 2).
    task automatic reset_mid(input int phase);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ctrl  = 4'b0010;
        bus.in_a     = 8'h7F;
        bus.in_b     = 8'h01;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (phase == 2) begin
            @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        m_cnt = 0;
        #1;
        chk_reset_vals(phase == 2 ? "rst_done" : "rst_exec");
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [3:0] C_LEGAL [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    initial begin
        n_vec         = 0;
        n_err         = 0;
        m_cnt         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = 4'h0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        run_cmd(4'b0010, 8'h7F, 8'h01, 0);
        run_cmd(4'b0110, 8'h05, 8'h05, 0);
        run_cmd(4'b0111, 8'h80, 8'h01, 1);
        run_cmd(4'b1100, 8'h0F, 8'hF0, 0);
        run_cmd(4'b0001, 8'h0F, 8'hF0, 2);
        run_cmd(4'b0000, 8'h3C, 8'h0F, 0);
        run_cmd(4'b0110, 8'h80, 8'h01, 0);
        run_cmd(4'b0010, 8'hAA, 8'h55, 5);
        run_cmd(4'b0011, 8'hFF, 8'hFF, 0);
        run_cmd(4'b0010, 8'h01, 8'hFF, 0);
        run_cmd(4'b1111, 8'h80, 8'h80, 1);

        reset_mid(1);
        reset_mid(2);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] c;
            if ($urandom_range(0, 4) == 0) c = 4'($urandom);
            else                           c = C_LEGAL[$urandom_range(0, 5)];
            run_cmd(c, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

`ifdef ALU_CMD_SEQ_OVF_CNT_EN
        for (int i = 0; i < 300; i++) begin
            run_cmd(4'b0010, 8'h40 + 8'($urandom_range(0, 63)), 8'h40, 0);
        end
        chk("ovf_count_sat", 32'(ovf_count), 32'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
